// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared format constants, bias helper and operand class encoding
// Ports: none (package only).
package float_pkg;

    localparam int E4M3_EXP_BITS = 4;
    localparam int E4M3_MAN_BITS = 3;
    localparam int BF16_EXP_BITS = 8;
    localparam int BF16_MAN_BITS = 7;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } float_class_t;

    function automatic int bias(input int exp_bits);
        return (1 << (exp_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_round_rne.sv
// rtl/float_round_rne.sv - round-to-nearest-even plus overflow/underflow/special packing
// Ports: sign, cls (result class), exp (signed biased exponent, EXP_BITS+2 bits),
//        man/guard/round/sticky (normalised fraction split), y (packed word, combinational).
module float_round_rne
    import float_pkg::*;
#(
    parameter int EXP_BITS = E4M3_EXP_BITS,
    parameter int MAN_BITS = E4M3_MAN_BITS,
    parameter int HAS_INF  = 0
) (
    input  logic                        sign,
    input  float_class_t                cls,
    input  logic signed [EXP_BITS+1:0]  exp,
    input  logic [MAN_BITS-1:0]         man,
    input  logic                        guard,
    input  logic                        round,
    input  logic                        sticky,
    output logic [EXP_BITS+MAN_BITS:0]  y
);

    typedef logic signed [EXP_BITS+1:0] sexp_t;

    localparam sexp_t ONE      = sexp_t'(1);
    localparam sexp_t EXP_TOP  = sexp_t'((1 << EXP_BITS) - 1);
    localparam logic [EXP_BITS-1:0] EXP_ONES = '1;
    localparam logic [MAN_BITS-1:0] MAN_ZERO = '0;
    localparam logic [MAN_BITS-1:0] MAN_ONES = '1;
    localparam logic [MAN_BITS-1:0] MAN_QNAN = {1'b1, {(MAN_BITS-1){1'b0}}};
    localparam logic [MAN_BITS-1:0] MAN_MAXF = {{(MAN_BITS-1){1'b1}}, 1'b0};

    logic                round_up;
    logic [MAN_BITS:0]   man_sum;
    logic [MAN_BITS-1:0] man_r;
    sexp_t               exp_r;

    always_comb begin
        round_up = guard & (round | sticky | man[0]);
        man_sum  = {1'b0, man} + {{MAN_BITS{1'b0}}, round_up};
        // A carry out leaves man_sum = 1000..0, so the low bits are already zero.
        man_r    = man_sum[MAN_BITS-1:0];
        exp_r    = exp + (man_sum[MAN_BITS] ? ONE : sexp_t'(0));

        y = {sign, {EXP_BITS{1'b0}}, MAN_ZERO};
        case (cls)
            CLS_NAN: begin
                if (HAS_INF != 0) y = {1'b0, EXP_ONES, MAN_QNAN};
                else              y = {1'b0, EXP_ONES, MAN_ONES};
            end
            CLS_INF:  y = {sign, EXP_ONES, MAN_ZERO};
            CLS_ZERO: y = {sign, {EXP_BITS{1'b0}}, MAN_ZERO};
            default: begin
                if (exp_r < ONE) begin
                    y = {sign, {EXP_BITS{1'b0}}, MAN_ZERO};
                end else if (HAS_INF != 0) begin
                    if (exp_r >= EXP_TOP) y = {sign, EXP_ONES, MAN_ZERO};
                    else                  y = {sign, exp_r[EXP_BITS-1:0], man_r};
                end else begin
                    // Top exponent is finite here; only the all-ones mantissa is NaN.
                    if (exp_r > EXP_TOP || (exp_r == EXP_TOP && man_r == MAN_ONES))
                        y = {sign, EXP_ONES, MAN_MAXF};
                    else
                        y = {sign, exp_r[EXP_BITS-1:0], man_r};
                end
            end
        endcase
    end

endmodule

// File: rtl/float_multiplier_pipe.sv
// rtl/float_multiplier_pipe.sv - pipelined small-float multiplier with valid/ready handshakes
// Ports: clock, reset (async, active-high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with product y (registered).
module float_multiplier_pipe
    import float_pkg::*;
#(
    parameter int EXP_BITS = E4M3_EXP_BITS,
    parameter int MAN_BITS = E4M3_MAN_BITS,
    parameter int HAS_INF  = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_BITS+MAN_BITS:0] a,
    input  logic [EXP_BITS+MAN_BITS:0] b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_BITS+MAN_BITS:0] y
);

    localparam int W  = 1 + EXP_BITS + MAN_BITS;
    localparam int EW = EXP_BITS + 2;
    localparam int PW = 2 * (MAN_BITS + 1);

    typedef logic signed [EW-1:0] sexp_t;

    localparam sexp_t BIAS = sexp_t'(bias(EXP_BITS));
    localparam sexp_t ONE  = sexp_t'(1);

    function automatic float_class_t classify(input logic [EXP_BITS-1:0] e,
                                              input logic [MAN_BITS-1:0] m);
        if (e == '0)                 return CLS_ZERO;
        else if (e != {EXP_BITS{1'b1}}) return CLS_NORMAL;
        else if (HAS_INF != 0)       return (m == '0) ? CLS_INF : CLS_NAN;
        else                         return (m == {MAN_BITS{1'b1}}) ? CLS_NAN : CLS_NORMAL;
    endfunction

    // Operand capture register; the S1 logic then works from clean flops.
    logic         op_valid;
    logic [W-1:0] op_a, op_b;

    logic         s1_valid, s1_sign;
    float_class_t s1_cls;
    sexp_t        s1_exp;
    logic [PW-1:0] s1_prod;

    logic         s2_valid, s2_sign;
    float_class_t s2_cls;
    sexp_t        s2_exp;
    logic [MAN_BITS-1:0] s2_man;
    logic         s2_guard, s2_round, s2_sticky;

    float_class_t ca, cb, cls_d;
    sexp_t        exp_d, nexp;
    logic [PW-1:0] prod_d;
    logic [PW-2:0] frac;
    logic [W-1:0]  packed_y;
    logic          advance;

    // Every stage moves together; only a held, unconsumed output freezes the pipe.
    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;

    always_comb begin
        ca = classify(op_a[W-2:MAN_BITS], op_a[MAN_BITS-1:0]);
        cb = classify(op_b[W-2:MAN_BITS], op_b[MAN_BITS-1:0]);
        if (ca == CLS_NAN || cb == CLS_NAN)
            cls_d = CLS_NAN;
        else if (ca == CLS_INF || cb == CLS_INF)
            cls_d = (ca == CLS_ZERO || cb == CLS_ZERO) ? CLS_NAN : CLS_INF;
        else if (ca == CLS_ZERO || cb == CLS_ZERO)
            cls_d = CLS_ZERO;
        else
            cls_d = CLS_NORMAL;
        exp_d  = sexp_t'({2'b00, op_a[W-2:MAN_BITS]}) + sexp_t'({2'b00, op_b[W-2:MAN_BITS]}) - BIAS;
        prod_d = PW'({1'b1, op_a[MAN_BITS-1:0]}) * PW'({1'b1, op_b[MAN_BITS-1:0]});
    end

    // Product of two [1,2) values lies in [1,4): shift out the leading one.
    always_comb begin
        if (s1_prod[PW-1]) begin
            frac = s1_prod[PW-2:0];
            nexp = s1_exp + ONE;
        end else begin
            frac = {s1_prod[PW-3:0], 1'b0};
            nexp = s1_exp;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_exp    <= '0;
            s1_prod   <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_cls    <= CLS_ZERO;
            s2_exp    <= '0;
            s2_man    <= '0;
            s2_guard  <= 1'b0;
            s2_round  <= 1'b0;
            s2_sticky <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
        end else if (advance) begin
            op_valid  <= in_valid;
            op_a      <= a;
            op_b      <= b;
            s1_valid  <= op_valid;
            s1_sign   <= op_a[W-1] ^ op_b[W-1];
            s1_cls    <= cls_d;
            s1_exp    <= exp_d;
            s1_prod   <= prod_d;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_cls    <= s1_cls;
            s2_exp    <= nexp;
            s2_man    <= frac[PW-2:MAN_BITS+1];
            s2_guard  <= frac[MAN_BITS];
            s2_round  <= frac[MAN_BITS-1];
            s2_sticky <= |frac[MAN_BITS-2:0];
            out_valid <= s2_valid;
            y         <= packed_y;
        end
    end

    float_round_rne #(
        .EXP_BITS (EXP_BITS),
        .MAN_BITS (MAN_BITS),
        .HAS_INF  (HAS_INF)
    ) u_round (
        .sign   (s2_sign),
        .cls    (s2_cls),
        .exp    (s2_exp),
        .man    (s2_man),
        .guard  (s2_guard),
        .round  (s2_round),
        .sticky (s2_sticky),
        .y      (packed_y)
    );

endmodule
